// File: rtl/scm_cfg_pkg.sv
// ---------------------------------------------------------------------------
// scm_cfg_pkg
//   Shared definitions for the SCM config-packet protocol: packet width,
//   opcodes, register offsets relative to the block base address, the
//   initiator state encoding and the packet packing helper. Used by both the
//   initiator (scm_cfg_master) and the responder side of the config chain.
// ---------------------------------------------------------------------------
package scm_cfg_pkg;

  localparam int PKT_W        = 134;
  localparam int N_STAT_WORDS = 6;

  // Packet opcodes, carried in bits [127:124].
  localparam logic [3:0] OP_WR  = 4'b1010;
  localparam logic [3:0] OP_RD  = 4'b1001;
  localparam logic [3:0] OP_RSP = 4'b1011;

  // Register offsets from the block base address.
  localparam logic [31:0] OFF_PROTOCOL   = 32'd0;
  localparam logic [31:0] OFF_STAT_RESET = 32'd1;
  localparam logic [31:0] OFF_N_RTT      = 32'd2;
  localparam logic [31:0] OFF_STAT0      = 32'd8;  // statistic words at +8..+D

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_DONE
  } cfg_state_e;

  // Layout: [133:128] hdr, [127:124] opcode, [123:96] zero, [95:64] addr,
  //         [63:32] zero, [31:0] data.
  function automatic logic [PKT_W-1:0] pack_cfg_pkt(input logic [5:0]  hdr,
                                                    input logic [3:0]  op,
                                                    input logic [31:0] addr,
                                                    input logic [31:0] data);
    return {hdr, op, 28'd0, addr, 32'd0, data};
  endfunction

endpackage

// File: rtl/scm_cfg_master.sv
// ---------------------------------------------------------------------------
// scm_cfg_master
//   Initiator for the SCM config chain. On start it writes the statistic
//   control registers (optional statistic_reset, protocol_type, n_RTT), then
//   reads the six 32-bit statistic words one at a time and presents them as
//   three 64-bit results. Each read waits for a matching RSP packet; if none
//   arrives within TIMEOUT_CYC cycles the sequence aborts with err_timeout.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    1-cycle launch pulse (ignored unless idle)
//   cfg_do_reset/protocol/n_rtt  sequence configuration, sampled at start
//   busy, done               sequence in progress / 1-cycle end pulse
//   err_timeout              sticky timeout flag, cleared by accepted start
//   result_valid             all six words captured without timeout
//   bit_num/pkt_num/time_cnt 64-bit results {hi word, lo word}
//   cout_data/cout_data_wr   request packet to the chain, 1-cycle valid
//   cin_ready                chain can accept a request
//   cin_data/cin_data_wr     packet returned by the chain
//   cout_ready               always 1: returned packets are never stalled
// ---------------------------------------------------------------------------
module scm_cfg_master
  import scm_cfg_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h7000_0000,
  parameter logic [5:0]  CFG_HDR     = 6'b000000,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cfg_do_reset,
  input  logic [7:0]         cfg_protocol,
  input  logic [31:0]        cfg_n_rtt,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic               result_valid,
  output logic [63:0]        bit_num,
  output logic [63:0]        pkt_num,
  output logic [63:0]        time_cnt,
  output logic [PKT_W-1:0]   cout_data,
  output logic               cout_data_wr,
  input  logic               cin_ready,
  input  logic [PKT_W-1:0]   cin_data,
  input  logic               cin_data_wr,
  output logic               cout_ready
);

  cfg_state_e        state_q, state_d;
  logic [1:0]        widx_q, widx_d;
  logic [2:0]        ridx_q, ridx_d;
  logic [15:0]       tmo_q, tmo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rv_q, rv_d;
  logic [7:0]        proto_q, proto_d;
  logic [31:0]       rtt_q, rtt_d;
  logic [PKT_W-1:0]  cout_data_q, cout_data_d;
  logic              cout_wr_q, cout_wr_d;
  logic [31:0]       words_q [N_STAT_WORDS];
  logic [31:0]       words_d [N_STAT_WORDS];

  logic [31:0]       wr_addr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_addr;
  logic              rsp_match;

  // Only opcode, address and data of a returned packet matter here.
  logic unused_cin_bits;
  assign unused_cin_bits = ^{cin_data[133:128], cin_data[123:96], cin_data[63:32]};

  // Write slot -> register: 0 statistic_reset, 1 protocol_type, 2 n_RTT.
  always_comb begin
    wr_addr = ADDR_BASE + OFF_N_RTT;
    wr_data = rtt_q;
    case (widx_q)
      2'd0: begin
        wr_addr = ADDR_BASE + OFF_STAT_RESET;
        wr_data = 32'd1;
      end
      2'd1: begin
        wr_addr = ADDR_BASE + OFF_PROTOCOL;
        wr_data = {24'd0, proto_q};
      end
      default: ;
    endcase
  end

  assign rd_addr   = ADDR_BASE + OFF_STAT0 + {29'd0, ridx_q};
  // Echoed writes and responses to other addresses fall through here.
  assign rsp_match = cin_data_wr && (cin_data[127:124] == OP_RSP) &&
                     (cin_data[95:64] == rd_addr);

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    ridx_d      = ridx_q;
    tmo_d       = tmo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    rv_d        = rv_q;
    proto_d     = proto_q;
    rtt_d       = rtt_q;
    cout_data_d = cout_data_q;
    cout_wr_d   = 1'b0;
    words_d     = words_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          proto_d = cfg_protocol;
          rtt_d   = cfg_n_rtt;
          rv_d    = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          widx_d  = cfg_do_reset ? 2'd0 : 2'd1;
          state_d = ST_WR_ISSUE;
        end
      end

      ST_WR_ISSUE: begin
        if (cin_ready) begin
          cout_data_d = pack_cfg_pkt(CFG_HDR, OP_WR, wr_addr, wr_data);
          cout_wr_d   = 1'b1;
          if (widx_q == 2'd2) begin
            ridx_d  = 3'd0;
            state_d = ST_RD_ISSUE;
          end else begin
            widx_d = widx_q + 2'd1;
          end
        end
      end

      ST_RD_ISSUE: begin
        if (cin_ready) begin
          cout_data_d = pack_cfg_pkt(CFG_HDR, OP_RD, rd_addr, 32'd0);
          cout_wr_d   = 1'b1;
          tmo_d       = 16'd0;
          state_d     = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        // A response arriving on the limit cycle still counts.
        if (rsp_match) begin
          words_d[ridx_q] = cin_data[31:0];
          if (ridx_q == 3'(N_STAT_WORDS - 1)) begin
            rv_d    = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            ridx_d  = ridx_q + 3'd1;
            state_d = ST_RD_ISSUE;
          end
        end else if (tmo_q == TIMEOUT_CYC - 16'd1) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      ST_DONE: begin
        // done is visible in this cycle; busy stays up until it ends so a
        // coincident start is not accepted.
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      widx_q      <= 2'd0;
      ridx_q      <= 3'd0;
      tmo_q       <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rv_q        <= 1'b0;
      proto_q     <= 8'd0;
      rtt_q       <= 32'd0;
      cout_data_q <= '0;
      cout_wr_q   <= 1'b0;
      for (int i = 0; i < N_STAT_WORDS; i++) words_q[i] <= 32'd0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      ridx_q      <= ridx_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rv_q        <= rv_d;
      proto_q     <= proto_d;
      rtt_q       <= rtt_d;
      cout_data_q <= cout_data_d;
      cout_wr_q   <= cout_wr_d;
      for (int i = 0; i < N_STAT_WORDS; i++) words_q[i] <= words_d[i];
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err_timeout  = err_q;
  assign result_valid = rv_q;
  assign bit_num      = {words_q[1], words_q[0]};
  assign pkt_num      = {words_q[3], words_q[2]};
  assign time_cnt     = {words_q[5], words_q[4]};
  assign cout_data    = cout_data_q;
  assign cout_data_wr = cout_wr_q;
  assign cout_ready   = 1'b1;

endmodule

// File: tb/tb_scm_cfg_master.sv
module tb_scm_cfg_master;

  localparam logic [31:0] BASE = 32'h7000_0000;
  localparam int          TMO  = 1024;
  localparam logic [3:0]  WR   = 4'b1010;
  localparam logic [3:0]  RD   = 4'b1001;
  localparam logic [3:0]  RSP  = 4'b1011;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cfg_do_reset = 1'b0;
  logic [7:0]   cfg_protocol = 8'h0;
  logic [31:0]  cfg_n_rtt = 32'h0;
  logic         busy, done, err_timeout, result_valid;
  logic [63:0]  bit_num, pkt_num, time_cnt;
  logic [133:0] cout_data;
  logic         cout_data_wr;
  logic         cin_ready = 1'b1;
  logic [133:0] cin_data;
  logic         cin_data_wr;
  logic         cout_ready;

  always #5 clk = ~clk;

  scm_cfg_master dut (
    .clk(clk), .rst(rst), .start(start), .cfg_do_reset(cfg_do_reset),
    .cfg_protocol(cfg_protocol), .cfg_n_rtt(cfg_n_rtt), .busy(busy), .done(done),
    .err_timeout(err_timeout), .result_valid(result_valid), .bit_num(bit_num),
    .pkt_num(pkt_num), .time_cnt(time_cnt), .cout_data(cout_data),
    .cout_data_wr(cout_data_wr), .cin_ready(cin_ready), .cin_data(cin_data),
    .cin_data_wr(cin_data_wr), .cout_ready(cout_ready)
  );

  function automatic logic [133:0] mk(input logic [3:0] op, input logic [31:0] addr,
                                      input logic [31:0] data);
    return {6'b000000, op, 28'h0, addr, 32'h0, data};
  endfunction

  // ---------------- loopback responder, latency 3 ----------------
  logic [31:0]  mem [16];
  logic [15:0]  silent = 16'h0;
  logic [133:0] p0 = '0, p1 = '0, p2 = '0;
  logic [2:0]   p_v = 3'b000;
  logic         inj_wr = 1'b0;
  logic [133:0] inj_data = '0;
  logic [3:0]   req_off, req_op;

  assign req_off = cout_data[67:64];
  assign req_op  = cout_data[127:124];

  always @(posedge clk) begin
    p_v[0] <= 1'b0;
    if (cout_data_wr) begin
      if (req_op == RD) begin
        if (!silent[req_off]) begin
          p_v[0] <= 1'b1;
          p0     <= mk(RSP, cout_data[95:64], mem[req_off]);
        end
      end else begin
        p_v[0] <= 1'b1;      // echo writes back, the master must ignore them
        p0     <= cout_data;
      end
    end
    p1     <= p0;
    p_v[1] <= p_v[0];
    p2     <= p1;
    p_v[2] <= p_v[1];
  end

  assign cin_data_wr = inj_wr | p_v[2];
  assign cin_data    = inj_wr ? inj_data : p2;

  // ---------------- monitor ----------------
  int           cyc = 0;
  int           last_rd_cyc = 0;
  int           done_cnt = 0;
  logic [133:0] pkt_log [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (cout_data_wr) begin
      pkt_log.push_back(cout_data);
      if (cout_data[127:124] == RD) last_rd_cyc <= cyc;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chkp(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_start(input logic dr, input logic [7:0] pr, input logic [31:0] rt);
    @(negedge clk);
    start = 1'b1;
    cfg_do_reset = dr;
    cfg_protocol = pr;
    cfg_n_rtt = rt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_log(input int n, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (pkt_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic             dr;
    logic [7:0]       pr;
    logic [31:0]      rt;
    logic [5:0][31:0] w;    // w[0] = word +8 ... w[5] = word +D
    logic [63:0]      eb, ep, et;
  } vec_t;

  vec_t tbl [3];

  task automatic load_mem(input vec_t v);
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    for (int i = 0; i < 6; i++) mem[8 + i] = v.w[i];
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit           ok;
    logic [133:0] exp_q [$];
    load_mem(v);
    pkt_log.delete();
    do_start(v.dr, v.pr, v.rt);
    chk1($sformatf("v%0d_busy_after_start", idx), busy, 1'b1);
    wait_done(300, ok);
    chk1($sformatf("v%0d_done_seen", idx), ok, 1'b1);
    chk1($sformatf("v%0d_result_valid", idx), result_valid, 1'b1);
    chk1($sformatf("v%0d_err_timeout", idx), err_timeout, 1'b0);
    chk64($sformatf("v%0d_bit_num", idx), bit_num, v.eb);
    chk64($sformatf("v%0d_pkt_num", idx), pkt_num, v.ep);
    chk64($sformatf("v%0d_time_cnt", idx), time_cnt, v.et);
    @(negedge clk);
    chk1($sformatf("v%0d_done_one_cycle", idx), done, 1'b0);
    chk1($sformatf("v%0d_busy_after_done", idx), busy, 1'b0);
    if (v.dr) exp_q.push_back(mk(WR, BASE + 32'd1, 32'd1));
    exp_q.push_back(mk(WR, BASE, {24'h0, v.pr}));
    exp_q.push_back(mk(WR, BASE + 32'd2, v.rt));
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(RD, BASE + 32'd8 + 32'(i), 32'd0));
    chki($sformatf("v%0d_pkt_count", idx), pkt_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pkt_log.size(); i++)
      chkp($sformatf("v%0d_pkt%0d", idx, i), pkt_log[i], exp_q[i]);
    $display("vector %0d: do_reset=%0b proto=%h rtt=%h bit=%h pkt=%h time=%h", idx,
             v.dr, v.pr, v.rt, bit_num, pkt_num, time_cnt);
  endtask

  initial begin
    bit ok;
    int d;
    int dc;

    tbl[0].dr = 1'b1; tbl[0].pr = 8'h06; tbl[0].rt = 32'd100;
    tbl[0].w  = {32'h0, 32'h10, 32'h0, 32'h5, 32'h1, 32'h40};
    tbl[0].eb = 64'h0000_0001_0000_0040; tbl[0].ep = 64'h5; tbl[0].et = 64'h10;

    tbl[1].dr = 1'b0; tbl[1].pr = 8'h11; tbl[1].rt = 32'hDEAD_BEEF;
    tbl[1].w  = {32'h9abc_def0, 32'h1234_5678, 32'h8000_0000, 32'h0,
                 32'hffff_ffff, 32'hffff_ffff};
    tbl[1].eb = 64'hffff_ffff_ffff_ffff; tbl[1].ep = 64'h8000_0000_0000_0000;
    tbl[1].et = 64'h9abc_def0_1234_5678;

    tbl[2].dr = 1'b1; tbl[2].pr = 8'hFF; tbl[2].rt = 32'h0;
    tbl[2].w  = {32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
    tbl[2].eb = 64'h0000_0002_0000_0001; tbl[2].ep = 64'h0000_0004_0000_0003;
    tbl[2].et = 64'h0000_0006_0000_0005;

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err_timeout, 1'b0);
    chk1("rst_rv", result_valid, 1'b0);
    chk1("rst_cout_wr", cout_data_wr, 1'b0);
    chk1("rst_cout_ready", cout_ready, 1'b1);
    chkp("rst_cout_data", cout_data, '0);
    chk64("rst_bit_num", bit_num, 64'h0);
    chk64("rst_time_cnt", time_cnt, 64'h0);
    $display("reset: busy=%0b done=%0b cout_ready=%0b", busy, done, cout_ready);

    // Table-driven full sequences
    for (int i = 0; i < 3; i++) run_vec(tbl[i], i);

    // Timeout: responder silent on +A
    load_mem(tbl[0]);
    silent = 16'h0400;
    pkt_log.delete();
    do_start(1'b1, 8'h06, 32'd100);
    wait_done(TMO + 200, ok);
    d = cyc - last_rd_cyc;
    chk1("tmo_done_seen", ok, 1'b1);
    chk1("tmo_err", err_timeout, 1'b1);
    chk1("tmo_rv", result_valid, 1'b0);
    chk1("tmo_window", (d >= TMO - 1) && (d <= TMO + 1), 1'b1);
    chk64("tmo_bit_num_kept", bit_num, tbl[0].eb);
    chki("tmo_pkt_count", pkt_log.size(), 6);
    @(negedge clk);
    chk1("tmo_busy_after", busy, 1'b0);
    chk1("tmo_err_sticky", err_timeout, 1'b1);
    silent = 16'h0;
    $display("timeout: cycles=%0d err=%0b rv=%0b", d, err_timeout, result_valid);

    // cin_ready low for 10 cycles in WR_ISSUE
    load_mem(tbl[0]);
    pkt_log.delete();
    cin_ready = 1'b0;
    do_start(1'b1, 8'h06, 32'd100);
    chk1("rdy_err_cleared", err_timeout, 1'b0);
    chk1("rdy_rv_cleared", result_valid, 1'b0);
    d = 0;
    for (int i = 0; i < 10; i++) begin
      if (cout_data_wr) d++;
      @(negedge clk);
    end
    chki("rdy_no_wr_while_low", d + pkt_log.size(), 0);
    cin_ready = 1'b1;
    wait_done(300, ok);
    chk1("rdy_done_seen", ok, 1'b1);
    chk1("rdy_rv", result_valid, 1'b1);
    chki("rdy_pkt_count", pkt_log.size(), 9);
    chkp("rdy_first_pkt", (pkt_log.size() > 0) ? pkt_log[0] : '0, mk(WR, BASE + 32'd1, 32'd1));
    $display("cin_ready stall: pkts=%0d rv=%0b", pkt_log.size(), result_valid);

    // Wrong-address / wrong-opcode returns while waiting for +9
    load_mem(tbl[0]);
    silent = 16'h0200;
    pkt_log.delete();
    do_start(1'b1, 8'h06, 32'd100);
    wait_log(5, 100, ok);
    chk1("inj_rd9_issued", ok, 1'b1);
    repeat (2) @(negedge clk);
    inj_data = mk(RSP, BASE + 32'd12, 32'hBAD0_BAD0);
    inj_wr = 1'b1;
    @(negedge clk);
    inj_data = mk(WR, BASE + 32'd9, 32'hBAD1_BAD1);
    @(negedge clk);
    inj_data = mk(RD, BASE + 32'd9, 32'hBAD2_BAD2);
    @(negedge clk);
    inj_wr = 1'b0;
    repeat (3) @(negedge clk);
    chki("inj_still_waiting", pkt_log.size(), 5);
    chk1("inj_busy", busy, 1'b1);
    inj_data = mk(RSP, BASE + 32'd9, 32'h0000_0077);
    inj_wr = 1'b1;
    @(negedge clk);
    inj_wr = 1'b0;
    silent = 16'h0;
    wait_done(300, ok);
    chk1("inj_done_seen", ok, 1'b1);
    chk64("inj_bit_num", bit_num, 64'h0000_0077_0000_0040);
    chk64("inj_time_cnt", time_cnt, 64'h10);
    chk1("inj_rv", result_valid, 1'b1);
    $display("inject: bit=%h time=%h", bit_num, time_cnt);

    // Reset during RD_WAIT
    load_mem(tbl[0]);
    silent = 16'h0100;
    pkt_log.delete();
    do_start(1'b1, 8'h06, 32'd100);
    wait_log(4, 100, ok);
    chk1("rstw_rd8_issued", ok, 1'b1);
    repeat (2) @(negedge clk);
    dc = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk1("rstw_busy", busy, 1'b0);
    chk1("rstw_rv", result_valid, 1'b0);
    chk1("rstw_cout_wr", cout_data_wr, 1'b0);
    chk64("rstw_bit_num", bit_num, 64'h0);
    chk64("rstw_pkt_num", pkt_num, 64'h0);
    chk64("rstw_time_cnt", time_cnt, 64'h0);
    rst = 1'b0;
    silent = 16'h0;
    repeat (10) @(negedge clk);
    chki("rstw_no_done", done_cnt - dc, 0);
    $display("reset in RD_WAIT: busy=%0b bit=%h", busy, bit_num);
    run_vec(tbl[1], 3);

    // start while busy and in the done cycle
    load_mem(tbl[2]);
    pkt_log.delete();
    dc = done_cnt;
    do_start(1'b1, 8'hFF, 32'h0);
    repeat (4) @(negedge clk);
    do_start(1'b0, 8'h55, 32'd7);
    wait_done(300, ok);
    chk1("dbl_done_seen", ok, 1'b1);
    start = 1'b1;
    cfg_do_reset = 1'b0;
    cfg_protocol = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chki("dbl_pkt_count", pkt_log.size(), 9);
    chki("dbl_done_count", done_cnt - dc, 1);
    chk1("dbl_busy", busy, 1'b0);
    chkp("dbl_proto_pkt", (pkt_log.size() > 1) ? pkt_log[1] : '0, mk(WR, BASE, 32'h0000_00FF));
    chk64("dbl_time_cnt", time_cnt, tbl[2].et);
    $display("start while busy: pkts=%0d dones=%0d", pkt_log.size(), done_cnt - dc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
